pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 11, meaning program-counter and branch-offset width.
REQ-002 SHALL have parameter START_ADDR, default 0, meaning PC value loaded on Start.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the performance counters.
REQ-004 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  one-cycle request to begin a program run.
REQ-007 Stall  input  1  hold the current instruction; no state advance.
REQ-008 Halt  input  1  the current instruction is a halt.
REQ-009 BranchEn  input  1  the current instruction is a conditional relative branch.
REQ-010 Taken  input  1  the branch condition flag is true.
REQ-011 Target  input  PC_W  signed two's-complement branch offset from the branch-offset lookup table.
REQ-012 PC  output  PC_W  registered instruction-memory address.
REQ-013 InstrValid  output  1  PC addresses an instruction to execute this cycle.
REQ-014 Done  output  1  the program has halted.
REQ-015 RetiredCount  output  CNT_W  instructions retired in the current run.
REQ-016 BranchCount  output  CNT_W  taken branches in the current run.

Function
REQ-017 SHALL implement a 3-state machine: IDLE, RUN, DONE.
REQ-018 IDLE: Start=1 -> RUN next cycle; PC<=START_ADDR; both counters cleared.
REQ-019 RUN: when Stall=1, PC, counters and state SHALL hold; Halt, BranchEn and Start are ignored.
REQ-020 RUN, Stall=0, Halt=1 -> DONE; PC holds; RetiredCount increments; Halt SHALL take priority over BranchEn.
REQ-021 RUN, Stall=0, Halt=0, BranchEn=1, Taken=1 -> PC<=PC+Target; BranchCount and RetiredCount increment.
REQ-022 RUN, Stall=0, Halt=0, otherwise -> PC<=PC+1; RetiredCount increments.
REQ-023 PC arithmetic SHALL be modulo 2^PC_W: the sum is truncated to PC_W bits, with wrap in both directions.
REQ-024 Start SHALL be ignored in RUN.
REQ-025 In DONE, Start=1 SHALL re-enter RUN exactly as from IDLE.
REQ-026 Done SHALL be 1 only in DONE and SHALL be held until the next Start.
REQ-027 InstrValid SHALL be 1 only in RUN; latency from Start to first InstrValid is 1 cycle.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1, never wrapping.
REQ-029 All outputs SHALL be driven from registers or from the state decode only; there is no combinational input-to-output path.

Reset
REQ-030 Reset_n=0 SHALL asynchronously force IDLE, PC=START_ADDR, Done=0, InstrValid=0, RetiredCount=0, BranchCount=0.
REQ-031 Reset asserted mid-run SHALL abort the run with no Done pulse.
REQ-032 The first Start is honoured on the first rising edge with Reset_n=1.

Structure
REQ-033 Package pc_fetch_pkg SHALL hold the state enum (IDLE/RUN/DONE) and defaults for PC_W and CNT_W.
REQ-034 One sub-module, sat_counter (CNT_W, clear, increment, saturate), SHALL be instantiated twice.
REQ-035 Target SHALL be sign-extended or truncated to PC_W inside pc_fetch; the lookup table is untouched.

Verification
REQ-036 Reset, Start, then 5 cycles with no branch -> PC=5, RetiredCount=5, InstrValid=1, Done=0.
REQ-037 PC=400, BranchEn=1, Taken=1, Target=-370 -> PC=30, BranchCount=1; same case with Taken=0 -> PC=401.
REQ-038 PC=2047 with increment -> PC=0; PC=5 with Target=-6 -> PC=2047.
REQ-039 Halt=1 and BranchEn=1 in the same cycle -> DONE, PC unchanged, Done=1 held for 10 cycles, then Start -> PC=0, counters=0.
REQ-040 Stall=1 for 3 cycles with Halt=1 -> PC, counters and state unchanged; Done=1 only after Stall drops.
REQ-041 Reset_n pulsed low mid-run at PC=17 -> immediately PC=0, IDLE, Done=0; Start while in RUN -> no effect.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and default widths for the program-counter fetch unit.
package pc_fetch_pkg;

    localparam int PC_W_DEFAULT  = 11;
    localparam int CNT_W_DEFAULT = 16;

    // Run-control states of the fetch sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the run statistics.
module sat_counter
    import pc_fetch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + 1'b1;
        end
        return result;
    endfunction

    // Clear wins over increment so a new run always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter fetch sequencer: IDLE/RUN/DONE control, relative branches,
// and retired/taken-branch statistics for the current run.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int PC_W       = PC_W_DEFAULT,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Start,
    input  logic                   Stall,
    input  logic                   Halt,
    input  logic                   BranchEn,
    input  logic                   Taken,
    input  logic signed [PC_W-1:0] Target,
    output logic [PC_W-1:0]        PC,
    output logic                   InstrValid,
    output logic                   Done,
    output logic [CNT_W-1:0]       RetiredCount,
    output logic [CNT_W-1:0]       BranchCount
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t                 state;
    logic signed [PC_W-1:0] offset;
    logic [PC_W-1:0]        pc_inc;
    logic [PC_W-1:0]        pc_branch;
    logic                   begin_run;
    logic                   retire;
    logic                   take_branch;

    // The offset table already delivers PC_W bits, so resizing is an identity
    // here; keeping it as a named signal makes the signed intent explicit.
    assign offset = Target;

    // Both sums are PC_W wide, so wrap-around in either direction is implicit.
    assign pc_inc    = PC + 1'b1;
    assign pc_branch = PC + $unsigned(offset);

    // Start only matters outside RUN; a stalled cycle retires nothing.
    assign begin_run   = (state != RUN) && Start;
    assign retire      = (state == RUN) && !Stall;
    assign take_branch = retire && !Halt && BranchEn && Taken;

    // Sequencer state, PC and the registered status outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            PC         <= START_PC;
            InstrValid <= 1'b0;
            Done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state      <= RUN;
                        PC         <= START_PC;
                        InstrValid <= 1'b1;
                        Done       <= 1'b0;
                    end
                end
                RUN: begin
                    if (!Stall) begin
                        if (Halt) begin
                            state      <= DONE;
                            InstrValid <= 1'b0;
                            Done       <= 1'b1;
                        end else if (BranchEn && Taken) begin
                            PC <= pc_branch;
                        end else begin
                            PC <= pc_inc;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    PC         <= START_PC;
                    InstrValid <= 1'b0;
                    Done       <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_retired (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clear (begin_run),
        .inc   (retire),
        .count (RetiredCount)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_branch (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clear (begin_run),
        .inc   (take_branch),
        .count (BranchCount)
    );

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a cycle model pushes expected outputs as
// stimulus is driven; a monitor pops and compares after each rising edge.
module tb_pc_fetch;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b1;
    logic               Start = 1'b0;
    logic               Stall = 1'b0;
    logic               Halt = 1'b0;
    logic               BranchEn = 1'b0;
    logic               Taken = 1'b0;
    logic signed [10:0] Target = '0;

    logic [10:0] PC;
    logic        InstrValid;
    logic        Done;
    logic [15:0] RetiredCount;
    logic [15:0] BranchCount;

    logic [10:0] pc_s;
    logic        valid_s;
    logic        done_s;
    logic [2:0]  ret_s;
    logic [2:0]  br_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [10:0] pc;
        logic        valid;
        logic        done;
        logic [15:0] ret;
        logic [15:0] br;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;

    // Reference model state: 0 idle, 1 run, 2 done.
    int          m_st;
    logic [10:0] m_pc;
    logic [15:0] m_ret;
    logic [15:0] m_br;

    pc_fetch dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Stall        (Stall),
        .Halt         (Halt),
        .BranchEn     (BranchEn),
        .Taken        (Taken),
        .Target       (Target),
        .PC           (PC),
        .InstrValid   (InstrValid),
        .Done         (Done),
        .RetiredCount (RetiredCount),
        .BranchCount  (BranchCount)
    );

    pc_fetch #(
        .PC_W       (11),
        .START_ADDR (0),
        .CNT_W      (3)
    ) dut_sat (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Stall        (Stall),
        .Halt         (Halt),
        .BranchEn     (BranchEn),
        .Taken        (Taken),
        .Target       (Target),
        .PC           (pc_s),
        .InstrValid   (valid_s),
        .Done         (done_s),
        .RetiredCount (ret_s),
        .BranchCount  (br_s)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_st  = 0;
        m_pc  = '0;
        m_ret = '0;
        m_br  = '0;
        exp_q.delete();
    endtask

    // Advance the model by one edge with the current inputs and queue the result.
    task automatic model_step();
        exp_t e;
        if (m_st != 1 && Start) begin
            m_st  = 1;
            m_pc  = '0;
            m_ret = '0;
            m_br  = '0;
        end else if (m_st == 1 && !Stall) begin
            if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
            if (Halt) begin
                m_st = 2;
            end else if (BranchEn && Taken) begin
                m_pc = 11'(m_pc + Target);
                if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
            end else begin
                m_pc = m_pc + 11'd1;
            end
        end
        e.pc    = m_pc;
        e.valid = (m_st == 1);
        e.done  = (m_st == 2);
        e.ret   = m_ret;
        e.br    = m_br;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic st, input logic stl, input logic hlt,
                         input logic ben, input logic tkn, input logic signed [10:0] tgt);
        @(negedge Clk);
        Start    = st;
        Stall    = stl;
        Halt     = hlt;
        BranchEn = ben;
        Taken    = tkn;
        Target   = tgt;
        model_step();
        @(posedge Clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Start = 1'b0; Stall = 1'b0; Halt = 1'b0; BranchEn = 1'b0; Taken = 1'b0; Target = '0;
        Reset_n = 1'b0;
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Scoreboard monitor: one expected entry per driven cycle.
    always @(posedge Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            checks++;
            if (PC !== sb_e.pc) begin
                errors++;
                $display("FAIL sb_pc: got %0d expected %0d at %0t", PC, sb_e.pc, $time);
            end
            checks++;
            if (InstrValid !== sb_e.valid) begin
                errors++;
                $display("FAIL sb_valid: got %b expected %b at %0t", InstrValid, sb_e.valid, $time);
            end
            checks++;
            if (Done !== sb_e.done) begin
                errors++;
                $display("FAIL sb_done: got %b expected %b at %0t", Done, sb_e.done, $time);
            end
            checks++;
            if (RetiredCount !== sb_e.ret) begin
                errors++;
                $display("FAIL sb_retired: got %0d expected %0d at %0t", RetiredCount, sb_e.ret, $time);
            end
            checks++;
            if (BranchCount !== sb_e.br) begin
                errors++;
                $display("FAIL sb_branch: got %0d expected %0d at %0t", BranchCount, sb_e.br, $time);
            end
        end
    end

    task automatic test_reset();
        #1 Reset_n = 1'b0;
        Start = 1'b1;
        model_reset();
        #2;
        checks++;
        if ({PC, InstrValid, Done, RetiredCount, BranchCount} !== 45'd0) begin
            errors++;
            $display("FAIL reset_state: got pc=%0d v=%b d=%b r=%0d b=%0d required all zero",
                     PC, InstrValid, Done, RetiredCount, BranchCount);
        end
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (InstrValid !== 1'b0 || PC !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold_start: got v=%b pc=%0d required v=0 pc=0", InstrValid, PC);
        end
        // Release and present Start together: the very next edge must begin the run.
        @(negedge Clk);
        Reset_n = 1'b1;
        Start   = 1'b1;
        model_step();
        @(posedge Clk);
        #2;
        checks++;
        if (InstrValid !== 1'b1 || PC !== 11'd0) begin
            errors++;
            $display("FAIL first_start: got v=%b pc=%0d required v=1 pc=0", InstrValid, PC);
        end
    endtask

    task automatic test_run_linear();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        steps(5);
        checks++;
        if (PC !== 11'd5 || RetiredCount !== 16'd5 || InstrValid !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL linear_run: got pc=%0d r=%0d v=%b d=%b required pc=5 r=5 v=1 d=0",
                     PC, RetiredCount, InstrValid, Done);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        steps(400);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -11'sd370);
        checks++;
        if (PC !== 11'd30 || BranchCount !== 16'd1 || RetiredCount !== 16'd401) begin
            errors++;
            $display("FAIL branch_taken: got pc=%0d b=%0d r=%0d required pc=30 b=1 r=401",
                     PC, BranchCount, RetiredCount);
        end
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        steps(400);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -11'sd370);
        checks++;
        if (PC !== 11'd401 || BranchCount !== 16'd0) begin
            errors++;
            $display("FAIL branch_not_taken: got pc=%0d b=%0d required pc=401 b=0", PC, BranchCount);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -11'sd1);
        checks++;
        if (PC !== 11'd2047) begin
            errors++;
            $display("FAIL wrap_down_to_top: got pc=%0d required 2047", PC);
        end
        steps(1);
        checks++;
        if (PC !== 11'd0) begin
            errors++;
            $display("FAIL wrap_inc_to_zero: got pc=%0d required 0", PC);
        end
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        steps(5);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -11'sd6);
        checks++;
        if (PC !== 11'd2047) begin
            errors++;
            $display("FAIL wrap_branch_neg: got pc=%0d required 2047", PC);
        end
    endtask

    task automatic test_halt_priority();
        int bad;
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        steps(3);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'sd100);
        checks++;
        if (Done !== 1'b1 || InstrValid !== 1'b0 || PC !== 11'd3 || RetiredCount !== 16'd4 || BranchCount !== 16'd0) begin
            errors++;
            $display("FAIL halt_priority: got d=%b v=%b pc=%0d r=%0d b=%0d required d=1 v=0 pc=3 r=4 b=0",
                     Done, InstrValid, PC, RetiredCount, BranchCount);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'sd7);
            if (Done !== 1'b1 || PC !== 11'd3) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL done_held: got %0d of 10 cycles wrong, required 0", bad);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        checks++;
        if (PC !== 11'd0 || RetiredCount !== 16'd0 || BranchCount !== 16'd0 || Done !== 1'b0 || InstrValid !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: got pc=%0d r=%0d b=%0d d=%b v=%b required pc=0 r=0 b=0 d=0 v=1",
                     PC, RetiredCount, BranchCount, Done, InstrValid);
        end
    endtask

    task automatic test_stall();
        int bad;
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        steps(2);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 11'sd5);
            if (PC !== 11'd2 || RetiredCount !== 16'd2 || InstrValid !== 1'b1 || Done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d of 3 cycles changed, required 0", bad);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'sd0);
        checks++;
        if (Done !== 1'b1 || PC !== 11'd2 || RetiredCount !== 16'd3) begin
            errors++;
            $display("FAIL halt_after_stall: got d=%b pc=%0d r=%0d required d=1 pc=2 r=3", Done, PC, RetiredCount);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        steps(17);
        checks++;
        if (PC !== 11'd17) begin
            errors++;
            $display("FAIL reach_17: got pc=%0d required 17", PC);
        end
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (PC !== 11'd0 || InstrValid !== 1'b0 || Done !== 1'b0 || RetiredCount !== 16'd0) begin
            errors++;
            $display("FAIL async_abort: got pc=%0d v=%b d=%b r=%0d required pc=0 v=0 d=0 r=0",
                     PC, InstrValid, Done, RetiredCount);
        end
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL no_done_after_abort: got d=%b required 0", Done);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        steps(3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        checks++;
        if (PC !== 11'd4 || RetiredCount !== 16'd4) begin
            errors++;
            $display("FAIL start_in_run: got pc=%0d r=%0d required pc=4 r=4", PC, RetiredCount);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'sd0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'sd1);
        checks++;
        if (ret_s !== 3'd5 || br_s !== 3'd5) begin
            errors++;
            $display("FAIL narrow_count: got r=%0d b=%0d required r=5 b=5", ret_s, br_s);
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'sd1);
        checks++;
        if (ret_s !== 3'd7 || br_s !== 3'd7 || pc_s !== 11'd10) begin
            errors++;
            $display("FAIL saturate: got r=%0d b=%0d pc=%0d required r=7 b=7 pc=10", ret_s, br_s, pc_s);
        end
        checks++;
        if (RetiredCount !== 16'd10 || BranchCount !== 16'd10) begin
            errors++;
            $display("FAIL wide_count: got r=%0d b=%0d required r=10 b=10", RetiredCount, BranchCount);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_linear();
        test_branch();
        test_wrap();
        test_halt_priority();
        test_stall();
        test_reset_midrun();
        test_saturation();
        repeat (2) @(posedge Clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
